// File: rtl/cp0_regfile_pkg.sv
// rtl/cp0_regfile_pkg.sv - CP0 register layouts, address map and exception codes
package coprocessor0_params;

    localparam logic [7:0] CP0_INDEX    = {5'd0,  3'd0};
    localparam logic [7:0] CP0_ENTRYLO0 = {5'd2,  3'd0};
    localparam logic [7:0] CP0_ENTRYLO1 = {5'd3,  3'd0};
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_ENTRYHI  = {5'd10, 3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    typedef struct packed {
        logic        p;
        logic [26:0] zero;
        logic [3:0]  index;
    } index_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [4:0]  zero;
        logic [7:0]  asid;
    } entry_hi_t;

    typedef struct packed {
        logic [5:0]  zero;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        g;
    } entry_lo_t;

    typedef struct packed {
        logic [8:0] zero3;
        logic       bev;
        logic [5:0] zero2;
        logic [7:0] im;
        logic [5:0] zero1;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero2;
        logic [5:0]  hw;
        logic [1:0]  sw;
        logic        zero1;
        logic [4:0]  exc_code;
        logic [1:0]  zero0;
    } cause_t;

    typedef struct packed {
        logic [31:0] exception_address;
        logic [7:0]  interrupt_valid;
    } cp0_to_if_bus_t;

    localparam status_t STATUS_RESET = 32'h0040_0000;

    // Address-related exceptions capture BadVAddr; the TLB ones also load EntryHi.VPN2
    function automatic logic sets_badvaddr(logic [4:0] code);
        return (code >= 5'(EXC_MOD)) && (code <= 5'(EXC_ADES));
    endfunction

    function automatic logic sets_vpn(logic [4:0] code);
        return (code >= 5'(EXC_MOD)) && (code <= 5'(EXC_TLBS));
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// rtl/cp0_regfile_if.sv - mtc0/mfc0 access bus between pipeline and CP0
interface cp0_regfile_if;
    logic        cp0_we;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;

    modport master (output cp0_we, output cp0_addr, output cp0_wdata, input cp0_rdata);
    modport slave  (input cp0_we, input cp0_addr, input cp0_wdata, output cp0_rdata);
endinterface

// File: rtl/cp0_regfile_timer.sv
// rtl/cp0_regfile_timer.sv - Count/Compare timer with half-rate tick and sticky compare interrupt
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_interrupt
);
    logic tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick            <= 1'b0;
            count           <= '0;
            compare         <= '0;
            timer_interrupt <= 1'b0;
        end else begin
            // A software Count write replaces the increment but leaves tick phase alone
            tick <= ~tick;
            if (count_we)
                count <= wdata;
            else if (tick)
                count <= count + 32'd1;
            if (compare_we)
                compare <= wdata;
            if (compare_we)
                timer_interrupt <= 1'b0;
            else if (count == compare)
                timer_interrupt <= 1'b1;
        end
    end
endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - MIPS CP0 register file: exceptions, eret, TLB regs, timer, interrupts
module cp0_regfile
    import coprocessor0_params::*;
#(
    parameter logic [31:0] EXC_ENTRY    = 32'hbfc00380,
    parameter logic [31:0] REFILL_ENTRY = 32'hbfc00200
) (
    input  logic            clk,
    input  logic            resetn,
    cp0_regfile_if.slave    cp0_bus,
    input  logic            ws_exception,
    input  logic [4:0]      ws_exc_code,
    input  logic            ws_bd,
    input  logic [31:0]     ws_pc,
    input  logic [31:0]     ws_badvaddr,
    input  logic            ws_tlb_refill,
    input  logic            ws_eret,
    input  logic [5:0]      ext_int,
    input  logic            tlbp_we,
    input  index_t          tlbp_index,
    input  logic            tlbr_we,
    input  entry_hi_t       tlbr_hi,
    input  entry_lo_t       tlbr_lo0,
    input  entry_lo_t       tlbr_lo1,
    output index_t          index_o,
    output entry_hi_t       entry_hi_o,
    output entry_lo_t       entry_lo0_o,
    output entry_lo_t       entry_lo1_o,
    output cp0_to_if_bus_t  cp0_to_if_bus
);
    index_t      index_r;
    entry_lo_t   entry_lo0_r;
    entry_lo_t   entry_lo1_r;
    entry_hi_t   entry_hi_r;
    status_t     status_r;
    logic [31:0] badvaddr_r;
    logic [31:0] epc_r;
    logic        cause_bd;
    logic [5:0]  cause_hw;
    logic [1:0]  cause_sw;
    logic [4:0]  cause_exc;
    cause_t      cause_v;

    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_irq;
    logic        count_we;
    logic        compare_we;

    assign count_we   = cp0_bus.cp0_we && (cp0_bus.cp0_addr == CP0_COUNT);
    assign compare_we = cp0_bus.cp0_we && (cp0_bus.cp0_addr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk             (clk),
        .resetn          (resetn),
        .count_we        (count_we),
        .compare_we      (compare_we),
        .wdata           (cp0_bus.cp0_wdata),
        .count           (count),
        .compare         (compare),
        .timer_interrupt (timer_irq)
    );

    // Later statements override earlier ones, giving exception > eret > tlb > mtc0 per field
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_r     <= '0;
            entry_lo0_r <= '0;
            entry_lo1_r <= '0;
            entry_hi_r  <= '0;
            status_r    <= STATUS_RESET;
            badvaddr_r  <= '0;
            epc_r       <= '0;
            cause_bd    <= 1'b0;
            cause_hw    <= '0;
            cause_sw    <= '0;
            cause_exc   <= '0;
        end else begin
            cause_hw <= {ext_int[5] | timer_irq, ext_int[4:0]};

            if (cp0_bus.cp0_we) begin
                case (cp0_bus.cp0_addr)
                    CP0_INDEX:    index_r.index      <= cp0_bus.cp0_wdata[3:0];
                    CP0_ENTRYLO0: entry_lo0_r[25:0]  <= cp0_bus.cp0_wdata[25:0];
                    CP0_ENTRYLO1: entry_lo1_r[25:0]  <= cp0_bus.cp0_wdata[25:0];
                    CP0_ENTRYHI: begin
                        entry_hi_r.vpn2 <= cp0_bus.cp0_wdata[31:13];
                        entry_hi_r.asid <= cp0_bus.cp0_wdata[7:0];
                    end
                    CP0_STATUS: begin
                        status_r.im  <= cp0_bus.cp0_wdata[15:8];
                        status_r.exl <= cp0_bus.cp0_wdata[1];
                        status_r.ie  <= cp0_bus.cp0_wdata[0];
                    end
                    CP0_CAUSE:    cause_sw <= cp0_bus.cp0_wdata[9:8];
                    CP0_EPC:      epc_r    <= cp0_bus.cp0_wdata;
                    default: ;
                endcase
            end

            if (tlbp_we)
                index_r <= tlbp_index;
            if (tlbr_we) begin
                entry_hi_r  <= tlbr_hi;
                entry_lo0_r <= tlbr_lo0;
                entry_lo1_r <= tlbr_lo1;
            end

            if (ws_eret)
                status_r.exl <= 1'b0;

            if (ws_exception) begin
                // Nested exceptions keep the original return point
                if (!status_r.exl) begin
                    epc_r    <= ws_bd ? ws_pc - 32'd4 : ws_pc;
                    cause_bd <= ws_bd;
                end
                status_r.exl <= 1'b1;
                cause_exc    <= ws_exc_code;
                if (sets_badvaddr(ws_exc_code))
                    badvaddr_r <= ws_badvaddr;
                if (sets_vpn(ws_exc_code))
                    entry_hi_r.vpn2 <= ws_badvaddr[31:13];
            end
        end
    end

    always_comb begin
        cause_v          = '0;
        cause_v.bd       = cause_bd;
        cause_v.ti       = timer_irq;
        cause_v.hw       = cause_hw;
        cause_v.sw       = cause_sw;
        cause_v.exc_code = cause_exc;
    end

    always_comb begin
        cp0_bus.cp0_rdata = '0;
        case (cp0_bus.cp0_addr)
            CP0_INDEX:    cp0_bus.cp0_rdata = index_r;
            CP0_ENTRYLO0: cp0_bus.cp0_rdata = entry_lo0_r;
            CP0_ENTRYLO1: cp0_bus.cp0_rdata = entry_lo1_r;
            CP0_BADVADDR: cp0_bus.cp0_rdata = badvaddr_r;
            CP0_COUNT:    cp0_bus.cp0_rdata = count;
            CP0_ENTRYHI:  cp0_bus.cp0_rdata = entry_hi_r;
            CP0_COMPARE:  cp0_bus.cp0_rdata = compare;
            CP0_STATUS:   cp0_bus.cp0_rdata = status_r;
            CP0_CAUSE:    cp0_bus.cp0_rdata = cause_v;
            CP0_EPC:      cp0_bus.cp0_rdata = epc_r;
            default:      cp0_bus.cp0_rdata = '0;
        endcase
    end

    always_comb begin
        cp0_to_if_bus = '0;
        cp0_to_if_bus.exception_address = ws_eret ? epc_r :
            ((ws_tlb_refill && !status_r.exl) ? REFILL_ENTRY : EXC_ENTRY);
        cp0_to_if_bus.interrupt_valid = (status_r.ie && !status_r.exl) ?
            (status_r.im & {cause_hw, cause_sw}) : 8'h00;
    end

    assign index_o     = index_r;
    assign entry_hi_o  = entry_hi_r;
    assign entry_lo0_o = entry_lo0_r;
    assign entry_lo1_o = entry_lo1_r;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - scoreboard bench for cp0_regfile against a word-level reference model
module tb_cp0_regfile;
    import coprocessor0_params::*;

    localparam logic [31:0] EXC    = 32'hbfc00380;
    localparam logic [31:0] REFILL = 32'hbfc00200;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cp0_regfile_if bus();
    logic        ws_exception, ws_bd, ws_tlb_refill, ws_eret, tlbp_we, tlbr_we;
    logic [4:0]  ws_exc_code;
    logic [31:0] ws_pc, ws_badvaddr;
    logic [5:0]  ext_int;
    index_t      tlbp_index, index_o;
    entry_hi_t   tlbr_hi, entry_hi_o;
    entry_lo_t   tlbr_lo0, tlbr_lo1, entry_lo0_o, entry_lo1_o;
    cp0_to_if_bus_t cp0_to_if_bus;

    cp0_regfile #(.EXC_ENTRY(EXC), .REFILL_ENTRY(REFILL)) dut (
        .clk(clk), .resetn(resetn), .cp0_bus(bus),
        .ws_exception(ws_exception), .ws_exc_code(ws_exc_code), .ws_bd(ws_bd),
        .ws_pc(ws_pc), .ws_badvaddr(ws_badvaddr), .ws_tlb_refill(ws_tlb_refill),
        .ws_eret(ws_eret), .ext_int(ext_int),
        .tlbp_we(tlbp_we), .tlbp_index(tlbp_index),
        .tlbr_we(tlbr_we), .tlbr_hi(tlbr_hi), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1),
        .index_o(index_o), .entry_hi_o(entry_hi_o), .entry_lo0_o(entry_lo0_o),
        .entry_lo1_o(entry_lo1_o), .cp0_to_if_bus(cp0_to_if_bus)
    );

    typedef struct {
        logic [31:0] rdata, exc_addr, idx, hi, lo0, lo1;
        logic [7:0]  intv;
        int          ksel;
        logic [31:0] kmask, kval;
        string       kname;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    int          k_sel = 0;
    logic [31:0] k_mask, k_val;
    string       k_name;

    logic [31:0] m_idx, m_lo0, m_lo1, m_badv, m_count, m_cmp, m_hi, m_status, m_epc;
    logic        m_bd, m_ti, m_tick;
    logic [4:0]  m_exc;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;

    logic [7:0] addr_tab [10] = '{CP0_INDEX, CP0_ENTRYLO0, CP0_ENTRYLO1, CP0_BADVADDR, CP0_COUNT,
                                  CP0_ENTRYHI, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC};

    function automatic void model_reset();
        {m_idx, m_lo0, m_lo1, m_badv, m_count, m_cmp, m_hi, m_epc} = '0;
        m_status = 32'h0040_0000;
        {m_bd, m_ti, m_tick, m_exc, m_sw, m_hw} = '0;
    endfunction

    function automatic logic [31:0] m_read(logic [7:0] a);
        case (a)
            CP0_INDEX:    return m_idx;
            CP0_ENTRYLO0: return m_lo0;
            CP0_ENTRYLO1: return m_lo1;
            CP0_BADVADDR: return m_badv;
            CP0_COUNT:    return m_count;
            CP0_ENTRYHI:  return m_hi;
            CP0_COMPARE:  return m_cmp;
            CP0_STATUS:   return m_status;
            CP0_CAUSE:    return {m_bd, m_ti, 14'b0, m_hw, m_sw, 1'b0, m_exc, 2'b0};
            CP0_EPC:      return m_epc;
            default:      return 32'h0;
        endcase
    endfunction

    function automatic void advance();
        logic [31:0] wd, o_count, o_cmp, o_status;
        logic        o_ti, o_tick;
        wd = bus.cp0_wdata;
        o_count = m_count; o_cmp = m_cmp; o_status = m_status; o_ti = m_ti; o_tick = m_tick;
        m_hw    = {ext_int[5] | o_ti, ext_int[4:0]};
        m_count = o_count + (o_tick ? 32'd1 : 32'd0);
        m_tick  = ~o_tick;
        m_ti    = (o_count == o_cmp) ? 1'b1 : o_ti;
        if (bus.cp0_we) begin
            case (bus.cp0_addr)
                CP0_INDEX:    m_idx = (m_idx & ~32'hf) | (wd & 32'hf);
                CP0_ENTRYLO0: m_lo0 = (m_lo0 & ~32'h03ffffff) | (wd & 32'h03ffffff);
                CP0_ENTRYLO1: m_lo1 = (m_lo1 & ~32'h03ffffff) | (wd & 32'h03ffffff);
                CP0_ENTRYHI:  m_hi = (m_hi & ~32'hffffe0ff) | (wd & 32'hffffe0ff);
                CP0_STATUS:   m_status = (m_status & ~32'h0000ff03) | (wd & 32'h0000ff03);
                CP0_CAUSE:    m_sw = wd[9:8];
                CP0_EPC:      m_epc = wd;
                CP0_COUNT:    m_count = wd;
                CP0_COMPARE:  begin m_cmp = wd; m_ti = 1'b0; end
                default: ;
            endcase
        end
        if (tlbp_we) m_idx = tlbp_index;
        if (tlbr_we) begin m_hi = tlbr_hi; m_lo0 = tlbr_lo0; m_lo1 = tlbr_lo1; end
        if (ws_eret) m_status[1] = 1'b0;
        if (ws_exception) begin
            if (!o_status[1]) begin
                m_epc = ws_bd ? ws_pc - 32'd4 : ws_pc;
                m_bd  = ws_bd;
            end
            m_status[1] = 1'b1;
            m_exc = ws_exc_code;
            if (ws_exc_code >= 5'd1 && ws_exc_code <= 5'd5) m_badv = ws_badvaddr;
            if (ws_exc_code >= 5'd1 && ws_exc_code <= 5'd3)
                m_hi = (m_hi & 32'h00001fff) | (ws_badvaddr & 32'hffffe000);
        end
    endfunction

    task automatic step();
        exp_t e;
        if (!resetn) model_reset();
        e.rdata    = m_read(bus.cp0_addr);
        e.exc_addr = ws_eret ? m_epc : ((ws_tlb_refill && !m_status[1]) ? REFILL : EXC);
        e.intv     = (m_status[0] && !m_status[1]) ? (m_status[15:8] & {m_hw, m_sw}) : 8'h00;
        e.idx = m_idx; e.hi = m_hi; e.lo0 = m_lo0; e.lo1 = m_lo1;
        e.ksel = k_sel; e.kmask = k_mask; e.kval = k_val; e.kname = k_name;
        sbq.push_back(e);
        k_sel = 0;
        @(posedge clk);
        if (resetn) advance(); else model_reset();
        #1;
    endtask

    function automatic void chk(string n, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", n, got, want, $time);
        end
    endfunction

    initial forever begin
        exp_t e;
        logic [31:0] kact;
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rdata", bus.cp0_rdata, e.rdata);
            chk("exc_addr", cp0_to_if_bus.exception_address, e.exc_addr);
            chk("int_valid", {24'h0, cp0_to_if_bus.interrupt_valid}, {24'h0, e.intv});
            chk("index_o", index_o, e.idx);
            chk("entry_hi_o", entry_hi_o, e.hi);
            chk("entry_lo0_o", entry_lo0_o, e.lo0);
            chk("entry_lo1_o", entry_lo1_o, e.lo1);
            if (e.ksel != 0) begin
                kact = (e.ksel == 1) ? bus.cp0_rdata :
                       (e.ksel == 2) ? {24'h0, cp0_to_if_bus.interrupt_valid} :
                                       cp0_to_if_bus.exception_address;
                chk(e.kname, kact & e.kmask, e.kval);
            end
        end
    end

    task automatic idle();
        bus.cp0_we = 1'b0; bus.cp0_addr = 8'h0; bus.cp0_wdata = 32'h0;
        ws_exception = 1'b0; ws_exc_code = 5'd0; ws_bd = 1'b0; ws_pc = 32'h0;
        ws_badvaddr = 32'h0; ws_tlb_refill = 1'b0; ws_eret = 1'b0; ext_int = 6'h0;
        tlbp_we = 1'b0; tlbp_index = '0; tlbr_we = 1'b0; tlbr_hi = '0; tlbr_lo0 = '0; tlbr_lo1 = '0;
    endtask

    task automatic kset(int sel, logic [31:0] mask, logic [31:0] val, string name);
        k_sel = sel; k_mask = mask; k_val = val; k_name = name;
    endtask

    task automatic read_k(logic [7:0] a, logic [31:0] mask, logic [31:0] val, string name);
        bus.cp0_addr = a;
        kset(1, mask, val, name);
        step();
    endtask

    task automatic mtc0(logic [7:0] a, logic [31:0] d);
        bus.cp0_we = 1'b1; bus.cp0_addr = a; bus.cp0_wdata = d;
        step();
        bus.cp0_we = 1'b0;
    endtask

    task automatic exception(logic [4:0] code, logic bd, logic [31:0] pc, logic [31:0] badv, logic refill);
        ws_exception = 1'b1; ws_exc_code = code; ws_bd = bd; ws_pc = pc;
        ws_badvaddr = badv; ws_tlb_refill = refill;
    endtask

    task automatic reset_mid_exception();
        exception(5'd2, 1'b1, 32'h8000_1234, 32'hfeed_0000, 1'b0);
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_EPC; bus.cp0_wdata = 32'h1111_2222;
        #2 resetn = 1'b0;
        step();
        resetn = 1'b1;
        idle();
        read_k(CP0_STATUS, 32'hffffffff, 32'h0040_0000, "status_after_abort");
        read_k(CP0_EPC, 32'hffffffff, 32'h0, "epc_after_abort");
    endtask

    logic [31:0] count_seq [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2};

    initial begin
        idle();
        resetn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        kset(3, 32'hffffffff, EXC, "reset_exc_addr");
        step();
        kset(2, 32'hff, 32'h0, "reset_int_valid");
        step();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) read_k(CP0_COUNT, 32'hffffffff, count_seq[i], "count_seq");
        read_k(CP0_STATUS, 32'hffffffff, 32'h0040_0000, "status_reset");

        mtc0(CP0_COMPARE, 32'd10);
        mtc0(CP0_COUNT, 32'd8);
        repeat (6) step();
        read_k(CP0_CAUSE, 32'h4000_0000, 32'h4000_0000, "ti_set");
        mtc0(CP0_STATUS, 32'h0000_8001);
        step();
        kset(2, 32'hff, 32'h80, "int_valid_timer");
        step();
        mtc0(CP0_COMPARE, 32'h0000_1000);
        read_k(CP0_CAUSE, 32'h4000_0000, 32'h0, "ti_clear");

        exception(5'd4, 1'b1, 32'hbfc00104, 32'h1, 1'b0);
        step();
        idle();
        read_k(CP0_EPC, 32'hffffffff, 32'hbfc00100, "epc_bd");
        read_k(CP0_CAUSE, 32'h8000_007c, 32'h8000_0010, "cause_bd_exc");
        read_k(CP0_BADVADDR, 32'hffffffff, 32'h1, "badvaddr");
        read_k(CP0_STATUS, 32'h2, 32'h2, "exl_set");

        exception(5'd8, 1'b0, 32'h8000_0000, 32'hdead_beef, 1'b0);
        step();
        idle();
        read_k(CP0_EPC, 32'hffffffff, 32'hbfc00100, "epc_nested");
        ws_eret = 1'b1;
        kset(3, 32'hffffffff, 32'hbfc00100, "eret_addr");
        step();
        idle();
        read_k(CP0_STATUS, 32'h2, 32'h0, "exl_clear");

        exception(5'd10, 1'b0, 32'h8000_0040, 32'h0, 1'b0);
        bus.cp0_we = 1'b1; bus.cp0_addr = CP0_STATUS; bus.cp0_wdata = 32'h0;
        step();
        idle();
        read_k(CP0_STATUS, 32'h0000_ff03, 32'h0000_0002, "exc_vs_mtc0");

        ws_eret = 1'b1;
        step();
        idle();
        exception(5'd2, 1'b0, 32'h8000_0100, 32'h1234_6abc, 1'b1);
        kset(3, 32'hffffffff, REFILL, "refill_addr");
        step();
        idle();
        read_k(CP0_ENTRYHI, 32'hffffe000, 32'h1234_6000, "refill_vpn");

        reset_mid_exception();

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 11);
            bus.cp0_addr  = (r < 10) ? addr_tab[r] : 8'($urandom());
            bus.cp0_we    = ($urandom_range(0, 3) == 0);
            bus.cp0_wdata = $urandom();
            if (bus.cp0_addr == CP0_COMPARE) bus.cp0_wdata = m_count + $urandom_range(0, 6);
            ws_exception  = ($urandom_range(0, 9) == 0);
            ws_exc_code   = 5'($urandom_range(0, 12));
            ws_bd         = 1'($urandom());
            ws_pc         = $urandom();
            ws_badvaddr   = $urandom();
            ws_tlb_refill = 1'($urandom());
            ws_eret       = ($urandom_range(0, 9) == 0);
            ext_int       = 6'($urandom());
            tlbp_we       = ($urandom_range(0, 7) == 0);
            tlbp_index    = $urandom();
            tlbr_we       = ($urandom_range(0, 7) == 0);
            tlbr_hi       = $urandom();
            tlbr_lo0      = $urandom();
            tlbr_lo1      = $urandom();
            step();
            if (n == 1500) reset_mid_exception();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have parameter EXC_ENTRY, default 32'hbfc00380, the general exception vector.
REQ-002 SHALL have parameter REFILL_ENTRY, default 32'hbfc00200, the TLB refill vector.
REQ-003 SHALL have port clk  in  1  sole clock; one clock, all state on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cp0_we in 1, cp0_addr in 8 ({rd[4:0],sel[2:0]}), cp0_wdata in 32, cp0_rdata out 32: mtc0/mfc0 access.
REQ-006 SHALL have ports ws_exception in 1, ws_exc_code in 5, ws_bd in 1, ws_pc in 32, ws_badvaddr in 32, ws_tlb_refill in 1: writeback exception commit.
REQ-007 SHALL have ports ws_eret in 1 (eret commit) and ext_int in 6 (hardware interrupt lines).
REQ-008 SHALL have ports tlbp_we in 1 with tlbp_index in index_t, and tlbr_we in 1 with tlbr_hi in entry_hi_t and tlbr_lo0/tlbr_lo1 in entry_lo_t.
REQ-009 SHALL have ports index_o, entry_hi_o, entry_lo0_o, entry_lo1_o out (package types): current values for tlbwi/tlbp.
REQ-010 SHALL have port cp0_to_if_bus out cp0_to_if_bus_t: exception_address and interrupt_valid.

Function
REQ-011 Registers SHALL be mapped as Index 0/0, EntryLo0 2/0, EntryLo1 3/0, BadVAddr 8/0, Count 9/0, EntryHi 10/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0; unmapped reads SHALL return 0.
REQ-012 cp0_rdata SHALL be combinational from current state; a same-cycle mtc0 to the read address SHALL NOT bypass (old value returned).
REQ-013 mtc0 SHALL write only: Index.index; EntryLo PFN/C/D/V/G; EntryHi VPN/ASID; Status IM/EXL/IE; Cause IP[1:0]; Count, Compare, EPC fully; zero fields and BEV SHALL stay unchanged.
REQ-014 Count SHALL increment by 1, wrapping 32'hffffffff to 0, on every second cycle via a 1-bit tick toggling each cycle from 0 after reset; mtc0 Count SHALL override the increment that cycle and SHALL NOT reset tick.
REQ-015 Cause.TI SHALL set the cycle after Count equals Compare; mtc0 Compare SHALL clear TI, with the clear winning if both occur in the same cycle.
REQ-016 Cause.hardware_interrupt SHALL register {ext_int[5] | TI, ext_int[4:0]} every cycle.
REQ-017 On ws_exception with Status.EXL=0: EPC SHALL become ws_bd ? ws_pc-4 : ws_pc, and Cause.BD SHALL become ws_bd; with EXL=1, EPC and BD SHALL be unchanged.
REQ-018 On ws_exception, regardless of EXL: EXL SHALL become 1 and ExcCode SHALL become ws_exc_code.
REQ-019 On ws_exception with exc_code in {1,2,3,4,5}, BadVAddr SHALL become ws_badvaddr; for codes 1..3, EntryHi.VPN SHALL become ws_badvaddr[31:13].
REQ-020 On ws_eret, EXL SHALL become 0.
REQ-021 For same-cycle events, the winner order SHALL be exception > eret > tlbr/tlbp > mtc0, applied per field; each field is written only by the highest-priority event that writes it.
REQ-022 tlbp_we SHALL write the whole Index; tlbr_we SHALL write EntryHi, EntryLo0, EntryLo1.
REQ-023 exception_address SHALL be combinational: ws_eret ? EPC : (ws_tlb_refill & ~EXL ? REFILL_ENTRY : EXC_ENTRY).
REQ-024 interrupt_valid SHALL be Status.IM & {Cause.hardware_interrupt, Cause.software_interrupt}, forced to 0 when IE=0 or EXL=1.

Reset
REQ-025 On resetn low, SHALL asynchronously clear all registers and tick, then set Status.BEV=1; interrupt_valid SHALL read 0 and exception_address SHALL read EXC_ENTRY.
REQ-026 Reset asserted mid-exception SHALL discard the pending commit; no partial update SHALL survive.

Structure
REQ-027 CP0 register address constants and the exception-code enum SHALL be added to coprocessor0_params; all register types come from there.
REQ-028 Count/Compare/tick/TI SHALL live in sub-module cp0_timer, with inputs for write enables and data and outputs count and timer_interrupt.

Verification
REQ-029 Reset, then read Status -> 32'h00400000; Count reads 0,0,1,1,2 over five cycles.
REQ-030 mtc0 Compare=10, Count=8 -> TI=1 two ticks later; set Status IM[7]=1, IE=1 -> interrupt_valid=8'h80; mtc0 Compare -> TI=0.
REQ-031 ws_exception code 4, bd=1, pc=32'hbfc00104, badvaddr=32'h1 -> EPC=32'hbfc00100, BD=1, BadVAddr=1, EXL=1, ExcCode=4.
REQ-032 Second exception with EXL=1, pc=32'h80000000 -> EPC unchanged; ws_eret -> exception_address=EPC, then EXL=0.
REQ-033 Same cycle ws_exception and mtc0 Status=0 -> EXL=1; IM and IE take the mtc0 value.
REQ-034 ws_exception code 2, refill=1, EXL=0 -> exception_address=32'hbfc00200, EntryHi.VPN=badvaddr[31:13].
